// File: rtl/vga_sync_receiver.sv
// VGA timing receiver: synchronizes hsync/vsync, recovers pixel/line position,
// checks line/frame timing and reports lock, active-area coordinates and errors.

module vga_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic pix_ce,
  input  logic sync_in,
  output logic fall,
  output logic rise
);
  logic s1, s2, prev;

  // Idle level of an active-low sync is high, so all flops reset to 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= 1'b1;
      s2   <= 1'b1;
      prev <= 1'b1;
    end else begin
      s1 <= sync_in;
      s2 <= s1;
      if (pix_ce) prev <= s2;
    end
  end

  assign fall = pix_ce & prev & ~s2;
  assign rise = pix_ce & ~prev & s2;
endmodule

module vga_sync_receiver #(
  parameter int H_TOTAL  = 800,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int H_ACTIVE = 640,
  parameter int V_TOTAL  = 525,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int V_ACTIVE = 480
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_ce,
  input  logic       hsync_in,
  input  logic       vsync_in,
  output logic       locked,
  output logic       de,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       frame_start,
  output logic       h_err,
  output logic       v_err,
  output logic [7:0] err_count
);
  localparam logic [10:0] H_LAST    = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_SYNC_LS = 11'(H_SYNC - 1);
  localparam logic [10:0] H_TMO_PRE = 11'(2 * H_TOTAL - 1);
  localparam logic [10:0] H_ACT_LO  = 11'(H_SYNC + H_BP);
  localparam logic [10:0] H_ACT_HI  = 11'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_SYNC_N  = 10'(V_SYNC);
  localparam logic [9:0]  V_ACT_LO  = 10'(V_SYNC + V_BP);
  localparam logic [9:0]  V_ACT_HI  = 10'(V_SYNC + V_BP + V_ACTIVE - 1);

  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

  state_t      state;
  logic [10:0] h_cnt, h_nxt;
  logic [9:0]  v_cnt, v_nxt;
  logic [1:0]  sync_pin, fall, rise;
  logic        hf, hr, vf, vr, checking, v_ok, h_bad, v_bad;

  // Index 0 = hsync, 1 = vsync.
  assign sync_pin = {vsync_in, hsync_in};

  for (genvar i = 0; i < 2; i++) begin : g_sync
    vga_sync_edge u_edge (
      .clk    (clk),
      .rst_n  (rst_n),
      .pix_ce (pix_ce),
      .sync_in(sync_pin[i]),
      .fall   (fall[i]),
      .rise   (rise[i])
    );
  end

  assign hf = fall[0];
  assign hr = rise[0];
  assign vf = fall[1];
  assign vr = rise[1];

  always_comb begin
    h_nxt = (h_cnt == 11'h7ff) ? h_cnt : h_cnt + 11'd1;
    if (hf || (vf && state == SEARCH)) h_nxt = '0;
    v_nxt = v_cnt;
    if (vf)                          v_nxt = '0;
    else if (hf && v_cnt != 10'h3ff) v_nxt = v_cnt + 10'd1;
    checking = (state != SEARCH);
    v_ok     = vf && (v_cnt == V_LAST);
    // Timeout fires on the step that would take h_cnt to 2*H_TOTAL.
    h_bad    = checking && ((hf && h_cnt != H_LAST) ||
                            (hr && h_cnt != H_SYNC_LS) ||
                            (pix_ce && !hf && h_cnt == H_TMO_PRE));
    v_bad    = checking && ((vf && !v_ok) || (vr && v_nxt != V_SYNC_N));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= SEARCH;
      locked      <= 1'b0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      frame_start <= 1'b0;
      h_err       <= 1'b0;
      v_err       <= 1'b0;
      err_count   <= '0;
    end else begin
      frame_start <= 1'b0;
      h_err       <= 1'b0;
      v_err       <= 1'b0;
      if ((h_err || v_err) && err_count != 8'hff) err_count <= err_count + 8'd1;
      if (pix_ce) begin
        h_cnt       <= h_nxt;
        v_cnt       <= v_nxt;
        h_err       <= h_bad;
        v_err       <= v_bad;
        frame_start <= checking && v_ok;
        case (state)
          SEARCH: if (vf) state <= ACQUIRE;
          ACQUIRE: begin
            if (h_bad || v_bad) state <= SEARCH;
            else if (v_ok) begin
              state  <= LOCKED;
              locked <= 1'b1;
            end
          end
          LOCKED: begin
            if (h_bad || v_bad) begin
              state  <= SEARCH;
              locked <= 1'b0;
            end
          end
          default: begin
            state  <= SEARCH;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

  assign de = locked && (h_cnt >= H_ACT_LO) && (h_cnt <= H_ACT_HI) &&
              (v_cnt >= V_ACT_LO) && (v_cnt <= V_ACT_HI);
  assign x  = de ? 10'(h_cnt - H_ACT_LO) : '0;
  assign y  = de ? 10'(v_cnt - V_ACT_LO) : '0;
endmodule

// File: tb/tb_vga_sync_receiver.sv
// Randomized bench for vga_sync_receiver with a scaled-down timing so whole
// frames fit in a short run; a pixel-level behavioural model checks every cycle.

module tb_vga_sync_receiver;
  localparam int HT = 40, HS = 6, HB = 4, HA = 24;
  localparam int VT = 20, VS = 2, VB = 3, VA = 12;
  localparam int XLO = HS + HB, YLO = VS + VB;

  logic       clk = 1'b0, rst_n = 1'b0, pix_ce = 1'b0;
  logic       hsync_in = 1'b1, vsync_in = 1'b1;
  logic       locked, de, frame_start, h_err, v_err;
  logic [9:0] x, y;
  logic [7:0] err_count;

  vga_sync_receiver #(
    .H_TOTAL(HT), .H_SYNC(HS), .H_BP(HB), .H_ACTIVE(HA),
    .V_TOTAL(VT), .V_SYNC(VS), .V_BP(VB), .V_ACTIVE(VA)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .locked(locked), .de(de), .x(x), .y(y),
    .frame_start(frame_start), .h_err(h_err), .v_err(v_err),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int gap_lo = 4, gap_hi = 4;
  int n_fs = 0, n_de = 0, max_x = 0, max_y = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0=search 1=acquire 2=locked; pins are seen two clocks late.
  int m_state, m_h, m_v, m_cnt;
  bit m_herr, m_verr, m_fs, m_hp, m_vp;
  bit hq[$], vq[$];

  task automatic model_reset();
    m_state = 0; m_h = 0; m_v = 0; m_cnt = 0;
    m_herr = 0; m_verr = 0; m_fs = 0; m_hp = 1; m_vp = 1;
    hq = '{1'b1, 1'b1};
    vq = '{1'b1, 1'b1};
  endtask

  task automatic model_step();
    bit hs, vs, hf, hr, vf, vr, chk, vok, he, ve;
    int nh, nv;
    if (m_herr || m_verr) m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
    m_herr = 0; m_verr = 0; m_fs = 0;
    hs = hq.pop_front();
    vs = vq.pop_front();
    hq.push_back(hsync_in);
    vq.push_back(vsync_in);
    if (pix_ce) begin
      hf = m_hp && !hs; hr = !m_hp && hs;
      vf = m_vp && !vs; vr = !m_vp && vs;
      m_hp = hs; m_vp = vs;
      chk = (m_state != 0);
      nh  = hf ? 0 : ((m_h < 2047) ? m_h + 1 : 2047);
      if (m_state == 0 && vf) nh = 0;
      nv  = vf ? 0 : (hf ? ((m_v < 1023) ? m_v + 1 : 1023) : m_v);
      vok = vf && (m_v == VT - 1);
      he  = chk && ((hf && m_h != HT - 1) || (hr && m_h != HS - 1) || (nh == 2 * HT));
      ve  = chk && ((vf && !vok) || (vr && nv != VS));
      m_fs = chk && vok;
      m_herr = he; m_verr = ve;
      if (m_state == 0) begin
        if (vf) m_state = 1;
      end else if (he || ve) m_state = 0;
      else if (vok) m_state = 2;
      m_h = nh; m_v = nv;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // Compare process: every negedge, all outputs against the model.
  initial begin : cmp
    bit e_lock, e_de;
    int e_x, e_y;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        e_lock = (m_state == 2);
        e_de   = e_lock && m_h >= XLO && m_h < XLO + HA && m_v >= YLO && m_v < YLO + VA;
        e_x    = e_de ? m_h - XLO : 0;
        e_y    = e_de ? m_v - YLO : 0;
        check("locked", locked, e_lock);
        check("de", de, e_de);
        check("x", x, e_x);
        check("y", y, e_y);
        check("frame_start", frame_start, m_fs);
        check("h_err", h_err, m_herr);
        check("v_err", v_err, m_verr);
        check("err_count", err_count, m_cnt);
      end else begin
        check("rst_outputs", {locked, de, x, y, frame_start, h_err, v_err, err_count}, 0);
      end
      if (pix_ce && de) begin
        n_de++;
        if (int'(x) > max_x) max_x = x;
        if (int'(y) > max_y) max_y = y;
      end
      if (frame_start) n_fs++;
    end
  end

  task automatic pix(input bit hs, input bit vs);
    int g;
    g = $urandom_range(gap_hi, gap_lo);
    hsync_in = hs; vsync_in = vs; pix_ce = 1'b1;
    @(posedge clk); #2;
    pix_ce = 1'b0;
    repeat (g - 1) begin @(posedge clk); #2; end
  endtask

  task automatic line(input int len, input int sw, input bit vs);
    for (int i = 0; i < len; i++) pix(i >= sw, vs);
  endtask

  task automatic frame(input int nlines);
    for (int l = 0; l < nlines; l++) line(HT, HS, l >= VS);
  endtask

  // Frame whose line lengths and sync widths are occasionally off by one.
  task automatic rand_frame();
    int len, sw;
    for (int l = 0; l < VT; l++) begin
      len = HT; sw = HS;
      if ($urandom_range(99, 0) < 15) len = ($urandom_range(1, 0) == 1) ? HT + 1 : HT - 1;
      if ($urandom_range(99, 0) < 15) sw  = ($urandom_range(1, 0) == 1) ? HS + 1 : HS - 1;
      line(len, sw, l >= VS);
    end
  endtask

  initial begin
    @(posedge clk); #2;
    // Reset held while syncs toggle.
    repeat (20) begin
      hsync_in = 1'($urandom); vsync_in = 1'($urandom); pix_ce = 1'($urandom);
      @(posedge clk); #2;
    end
    check("rst_locked", locked, 0);
    check("rst_err_count", err_count, 0);
    rst_n = 1'b1;
    pix_ce = 1'b0;
    repeat (30) pix(1'($urandom), 1'b1);
    repeat (3) pix(1'b1, 1'b1);
    check("search_no_vfall", locked, 0);

    // Nominal stream, pix_ce every 4th clk.
    n_fs = 0; n_de = 0; max_x = 0; max_y = 0;
    frame(VT);
    check("unlocked_after_f1", locked, 0);
    line(HT, HS, 1'b0);
    check("lock_at_vfall2", locked, 1);
    for (int l = 1; l < VT; l++) line(HT, HS, l >= VS);
    frame(VT);
    check("frame_start_count", n_fs, 2);
    check("de_pixels", n_de, 2 * HA * VA);
    check("max_x", max_x, HA - 1);
    check("max_y", max_y, VA - 1);
    check("nominal_err_count", err_count, 0);

    // Short line while locked, then relock two vsync falls later.
    gap_lo = 2; gap_hi = 4;
    for (int l = 0; l < VT; l++) line((l == 5) ? HT - 1 : HT, HS, l >= VS);
    check("short_line_err", err_count, 1);
    check("short_line_unlock", locked, 0);
    line(HT, HS, 1'b0);
    check("acquire_not_locked", locked, 0);
    for (int l = 1; l < VT; l++) line(HT, HS, l >= VS);
    line(HT, HS, 1'b0);
    check("relock", locked, 1);
    for (int l = 1; l < VT; l++) line(HT, HS, l >= VS);

    // Narrow hsync, then a frame one line short.
    for (int l = 0; l < VT; l++) line(HT, (l == 4) ? HS - 1 : HS, l >= VS);
    check("narrow_sync_err", err_count, 2);
    frame(VT - 1);
    line(HT, HS, 1'b0);
    check("short_frame_err", err_count, 3);
    check("short_frame_unlock", locked, 0);
    for (int l = 1; l < VT; l++) line(HT, HS, l >= VS);
    frame(VT);
    line(HT, HS, 1'b0);
    check("relock2", locked, 1);
    for (int l = 1; l < VT; l++) line(HT, HS, l >= VS);

    // hsync held high: one timeout error only.
    repeat (3 * HT) pix(1'b1, 1'b1);
    check("timeout_err", err_count, 4);
    check("timeout_unlock", locked, 0);

    // Repeated one-error cycles through ACQUIRE saturate the counter.
    repeat (300) begin
      pix(1'b0, 1'b0); pix(1'b1, 1'b0); pix(1'b1, 1'b0);
      pix(1'b0, 1'b1); pix(1'b1, 1'b1); pix(1'b1, 1'b1);
    end
    check("err_saturate", err_count, 255);

    // Randomized timing glitches, then clean frames to a guaranteed lock.
    rand_frame();
    rand_frame();
    frame(VT);
    frame(VT);
    for (int l = 0; l < 9; l++) line(HT, HS, l >= VS);
    for (int i = 0; i < 15; i++) pix(i >= HS, 1'b1);
    check("pre_rst_locked", locked, 1);
    check("pre_rst_de", de, 1);

    // Mid-frame reset clears everything immediately.
    rst_n = 1'b0;
    #1;
    check("midrst_locked", locked, 0);
    check("midrst_de", de, 0);
    check("midrst_err_count", err_count, 0);
    check("midrst_pulses", {frame_start, h_err, v_err}, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (10) pix(1'b1, 1'b1);
    check("post_rst_search", locked, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vga_sync_receiver.md
Name: vga_sync_receiver

Overview:
- Receive end of the team's VGA timing interface: consumes hSync/vSync, recovers pixel/line position, checks 640x480@60 timing, reports lock.
- Used on capture/loopback paths and as a self-checking monitor behind the display controller's outputs.
- Runs on the system clk, gated by a one-in-N pixel clock enable.
- Provides lock status, recovered active-area coordinates, data-enable, frame strobe and error counters.

Parameters:
H_TOTAL, 800, pixels per line
H_SYNC, 96, hsync low width in pixels
H_BP, 48, back porch; active x starts at H_SYNC+H_BP = 144
H_ACTIVE, 640, active pixels per line
V_TOTAL, 525, lines per frame
V_SYNC, 2, vsync low width in lines
V_BP, 33, back porch; active y starts at line 35
V_ACTIVE, 480, active lines per frame

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
pix_ce  in  1  pixel enable, one clk cycle wide; all counting happens only on clk edges with pix_ce=1
hsync_in  in  1  horizontal sync, active low, asynchronous to clk
vsync_in  in  1  vertical sync, active low, asynchronous to clk
locked  out  1  high in LOCKED state
de  out  1  data enable: locked and position inside the active area
x  out  10  active pixel column 0..639, valid while de=1, 0 otherwise
y  out  10  active line 0..479, valid while de=1, 0 otherwise
frame_start  out  1  one-clk pulse on every accepted vsync falling edge
h_err  out  1  one-clk pulse on a line-timing violation
v_err  out  1  one-clk pulse on a frame-timing violation
err_count  out  8  number of h_err/v_err events, saturating at 255

Behaviour:
- Reset state: every output 0, FSM=SEARCH, counters 0, synchronizer flops 1 (sync idle high).
- Synchronization: each sync input passes 2 clk flops. A third flop, updated only on pix_ce, holds the previous sample. Edge detection compares the synchronized value against that held sample on pix_ce cycles.
- h_cnt (11 bit):
  - On hsync falling edge: h_cnt <= 0.
  - Otherwise: h_cnt <= h_cnt+1, saturating at 2047.
- v_cnt (10 bit):
  - Increments on each hsync falling edge, saturating at 1023.
  - Set to 0 when a vsync falling edge occurs in the same sample.
- Line checks, active in ACQUIRE and LOCKED:
  - At hsync fall, the pre-update h_cnt must equal H_TOTAL-1.
  - At hsync rise, the pre-update h_cnt must equal H_SYNC-1.
  - A failed check raises h_err.
- Frame checks, active in ACQUIRE and LOCKED:
  - At vsync fall, the pre-update v_cnt must equal V_TOTAL-1.
  - At vsync rise, the post-update v_cnt must equal V_SYNC.
  - A failed check raises v_err.
- Both vsync edges coincide with an hsync falling edge. The line check and the frame check are both evaluated in that same sample.
- Timeout: h_cnt reaching 2*H_TOTAL (1600) raises h_err once and forces SEARCH.
- FSM:
  - SEARCH: counters free-run, no checks. On vsync fall -> ACQUIRE, with h_cnt=0 and v_cnt=0.
  - ACQUIRE: on any h_err/v_err -> SEARCH. On a vsync fall with the frame check passing -> LOCKED.
  - LOCKED: on any h_err/v_err -> SEARCH. Otherwise stay.
- frame_start pulses on a vsync fall in ACQUIRE or LOCKED whose frame check passes.
- err_count increments by 1 per clk in which h_err or v_err is high. Simultaneous h_err and v_err count as 1. It does not wrap and is cleared only by rst_n.
- de, x and y are combinational from the registers:
  - de = locked && h_cnt in [144,783] && v_cnt in [35,514].
  - x = h_cnt-144 and y = v_cnt-35 while de=1, else 0.
- Latency: a sync edge at the pins is acted on at the first pix_ce occurring at least 2 clk after it is captured. Pulse outputs are registered and last exactly 1 clk.
- rst_n asserted mid-frame: immediate return to reset values; no pulse is emitted.

Test Plan:
- rst_n=0 with toggling syncs -> locked=0, de=0, err_count=0; after release FSM stays SEARCH until the first vsync fall.
- Nominal 800x525 stream (pix_ce every 4th clk), 3 frames:
  - locked rises at the second vsync fall.
  - frame_start pulses at frames 2 and 3.
  - de is high for exactly 640x480 pixels per locked frame, with x 0..639 and y 0..479; err_count=0.
- Locked, then one 799-pixel line -> one h_err pulse, err_count=1, locked=0; relock at the second subsequent vsync fall.
- Locked, then hsync low for 95 pixels -> h_err at the rise; frame of 524 lines -> v_err at the vsync fall; err_count counts both.
- Locked, then hsync held high -> h_err exactly once at h_cnt=1600, locked=0, no further errors until syncs resume.
- 300 consecutive bad lines in ACQUIRE/SEARCH cycling -> err_count saturates at 255; mid-frame rst_n -> everything 0 within the same clk.
